// File: rtl/vernier_pt_unmap.sv
// vernier_pt_unmap: inverse of the vernier point map (tap index -> Average count).
// Scans tap indices T_MIN..T_MAX one per clock and returns the tap whose mapped
// value equals the requested target, or otherwise the floor entry (largest
// mapped value not above the target).
// Optional build macro: VERNIER_UNMAP_EARLY_EXIT_EN -- when defined, an exact
// match ends the scan at the edge that finds it; otherwise the scan always
// covers the full tap range.
module vernier_pt_unmap #(
  parameter int T_MIN = 2,
  parameter int T_MAX = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] target,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  resp_t,
  output logic [15:0] resp_value,
  output logic        resp_exact,
  output logic        resp_found,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] T_MIN_C = 7'(T_MIN);
  localparam logic [6:0] T_MAX_C = 7'(T_MAX);

  // Forward map built from shifts and adds: 80T = 64T + 16T, 16T = T << 4.
  function automatic logic [15:0] map_value(input logic [6:0] t);
    logic [15:0] t16;
    t16 = {9'd0, t};
    if ((t < 7'd2) || (t > 7'd120)) begin
      map_value = 16'd0;
    end else if ((t % 7'd5) == 7'd3) begin
      map_value = (t16 << 4) + 16'd2;
    end else begin
      map_value = (t16 << 6) + (t16 << 4) + 16'd10;
    end
  endfunction

  state_t      state_r, state_nx_s;
  logic [6:0]  t_cnt_r, t_cnt_nx_s;
  logic [15:0] target_r, target_nx_s;
  logic [6:0]  best_t_r, best_t_nx_s;
  logic [15:0] best_val_r, best_val_nx_s;
  logic        found_r, found_nx_s;
  logic        exact_r, exact_nx_s;
  logic [15:0] map_v_s;
  logic        qual_s;
  logic        hit_s;

  logic        resp_valid_r;
  logic [7:0]  resp_t_r;
  logic [15:0] resp_value_r;
  logic        resp_exact_r;
  logic        resp_found_r;
  logic        busy_r;

  // Next-state and scan bookkeeping: evaluate the current tap and track the floor entry.
  always_comb begin
    state_nx_s    = state_r;
    t_cnt_nx_s    = t_cnt_r;
    target_nx_s   = target_r;
    best_t_nx_s   = best_t_r;
    best_val_nx_s = best_val_r;
    found_nx_s    = found_r;
    exact_nx_s    = exact_r;
    map_v_s       = map_value(t_cnt_r);
    qual_s        = (map_v_s <= target_r) && (!found_r || (map_v_s > best_val_r));
    hit_s         = (map_v_s == target_r);
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          target_nx_s   = target;
          t_cnt_nx_s    = T_MIN_C;
          best_t_nx_s   = 7'd0;
          best_val_nx_s = 16'd0;
          found_nx_s    = 1'b0;
          exact_nx_s    = 1'b0;
          state_nx_s    = SCAN;
        end else begin
          state_nx_s    = IDLE;
        end
      end
      SCAN: begin
        if (qual_s) begin
          best_t_nx_s   = t_cnt_r;
          best_val_nx_s = map_v_s;
          found_nx_s    = 1'b1;
        end else begin
          best_t_nx_s   = best_t_r;
          best_val_nx_s = best_val_r;
          found_nx_s    = found_r;
        end
        if (hit_s) begin
          exact_nx_s = 1'b1;
        end else begin
          exact_nx_s = exact_r;
        end
        t_cnt_nx_s = t_cnt_r + 7'd1;
        if (t_cnt_r == T_MAX_C) begin
          state_nx_s = DONE;
`ifdef VERNIER_UNMAP_EARLY_EXIT_EN
        end else if (hit_s) begin
          state_nx_s = DONE;
`endif
        end else begin
          state_nx_s = SCAN;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, scan registers and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      t_cnt_r      <= 7'd0;
      target_r     <= 16'd0;
      best_t_r     <= 7'd0;
      best_val_r   <= 16'd0;
      found_r      <= 1'b0;
      exact_r      <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_t_r     <= 8'd0;
      resp_value_r <= 16'd0;
      resp_exact_r <= 1'b0;
      resp_found_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      t_cnt_r    <= t_cnt_nx_s;
      target_r   <= target_nx_s;
      best_t_r   <= best_t_nx_s;
      best_val_r <= best_val_nx_s;
      found_r    <= found_nx_s;
      exact_r    <= exact_nx_s;
      busy_r     <= (state_nx_s != IDLE);
      if ((state_r == SCAN) && (state_nx_s == DONE)) begin
        resp_valid_r <= 1'b1;
        resp_t_r     <= {1'b0, best_t_nx_s};
        resp_value_r <= best_val_nx_s;
        resp_exact_r <= exact_nx_s;
        resp_found_r <= found_nx_s;
      end else if ((state_r == DONE) && resp_ready) begin
        resp_valid_r <= 1'b0;
      end else begin
        resp_valid_r <= resp_valid_r;
      end
    end
  end

  // Ready only in IDLE, and forced low while reset is asserted.
  assign req_ready  = (state_r == IDLE) && !rst;
  assign resp_valid = resp_valid_r;
  assign resp_t     = resp_t_r;
  assign resp_value = resp_value_r;
  assign resp_exact = resp_exact_r;
  assign resp_found = resp_found_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_vernier_pt_unmap.sv
// Directed self-checking bench for vernier_pt_unmap with hand-computed results.
module tb_vernier_pt_unmap;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] target;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_t;
  logic [15:0] resp_value;
  logic        resp_exact;
  logic        resp_found;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef VERNIER_UNMAP_EARLY_EXIT_EN
  localparam int LAT_1010 = 62;
  localparam int LAT_50   = 2;
  localparam int LAT_330  = 3;
`else
  localparam int LAT_1010 = 119;
  localparam int LAT_50   = 119;
  localparam int LAT_330  = 119;
`endif

  vernier_pt_unmap dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .target     (target),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_t     (resp_t),
    .resp_value (resp_value),
    .resp_exact (resp_exact),
    .resp_found (resp_found),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for req_ready, present one request, and check it was taken at that edge.
  task automatic send_req(input logic [15:0] tg, output int waited);
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("req_ready_before_send", 32'(req_ready), 32'd1);
    target    = tg;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    target    = 16'h1234;
    check_eq("busy_after_accept", 32'(busy), 32'd1);
    check_eq("req_ready_in_scan", 32'(req_ready), 32'd0);
  endtask

  // Count edges after the accepting edge until resp_valid rises, then check the result.
  task automatic wait_check(input string tag, input int exp_lat, input logic [7:0] et,
                            input logic [15:0] ev, input logic ex, input logic fd);
    int lat;
    lat = 0;
    while (!resp_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_t"}, 32'(resp_t), 32'(et));
    check_eq({tag, "_value"}, 32'(resp_value), 32'(ev));
    check_eq({tag, "_exact"}, 32'(resp_exact), 32'(ex));
    check_eq({tag, "_found"}, 32'(resp_found), 32'(fd));
    check_eq({tag, "_req_ready_done"}, 32'(req_ready), 32'd0);
  endtask

  // Accept the response and confirm the return to IDLE on the next cycle.
  task automatic release_resp(input string tag);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    target     = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_t", 32'(resp_t), 32'd0);
    check_eq("rst_resp_value", 32'(resp_value), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Floor selection: 970 (T=12) beats 930 (T=58)
    send_req(16'd1000, w);
    wait_check("t1000", 119, 8'd12, 16'd970, 1'b0, 1'b1);
    release_resp("t1000");

    send_req(16'd1010, w);
    wait_check("t1010", LAT_1010, 8'd63, 16'd1010, 1'b1, 1'b1);
    release_resp("t1010");

    send_req(16'd40, w);
    wait_check("t40", 119, 8'd0, 16'd0, 1'b0, 1'b0);
    release_resp("t40");

    send_req(16'd50, w);
    wait_check("t50", LAT_50, 8'd3, 16'd50, 1'b1, 1'b1);
    release_resp("t50");

    // Saturated target, then hold in DONE with an ignored request pulse
    send_req(16'd65535, w);
    wait_check("t65535", 119, 8'd120, 16'd9610, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        target    = 16'd50;
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(resp_valid), 32'd1);
      check_eq("hold_t", 32'(resp_t), 32'd120);
      check_eq("hold_value", 32'(resp_value), 32'd9610);
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    release_resp("t65535");

    // Next request taken the cycle right after returning to IDLE
    send_req(16'd9610, w);
    check_eq("t9610_no_wait", 32'(w), 32'd0);
    wait_check("t9610", 119, 8'd120, 16'd9610, 1'b1, 1'b1);
    release_resp("t9610");

    // Reset in the middle of a scan discards the pending result
    send_req(16'd1000, w);
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_valid", 32'(resp_valid), 32'd0);
    check_eq("mid_rst_t", 32'(resp_t), 32'd0);
    check_eq("mid_rst_value", 32'(resp_value), 32'd0);
    check_eq("mid_rst_exact", 32'(resp_exact), 32'd0);
    check_eq("mid_rst_found", 32'(resp_found), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_idle_ready", 32'(req_ready), 32'd1);
    repeat (80) @(posedge clk);
    #1;
    check_eq("mid_rst_no_resp", 32'(resp_valid), 32'd0);

    send_req(16'd330, w);
    wait_check("t330", LAT_330, 8'd4, 16'd330, 1'b1, 1'b1);
    release_resp("t330");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
